// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory access sequencer: FSM encoding and defaults.
package mem_seq_pkg;

  // Sequencer state encoding (2 bits)
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_WAIT = 2'd1;
  localparam logic [1:0] S_D_WAIT  = 2'd2;

  // Default watchdog limit in wait cycles
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wait_timer.sv
// Wait-cycle watchdog: counts stalled memory cycles and flags when the limit is reached.
module wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  // Counter: clear has priority over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Limit reached
  always_comb begin
    hit = (count_q == CNT_W'(TIMEOUT));
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// stalling the core while an access is outstanding and aborting stuck accesses.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              err,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  logic [1:0] state_q;
  logic       waiting;
  logic       timer_clear;
  logic       timer_en;
  logic       timer_hit;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .enable(timer_en),
    .hit   (timer_hit)
  );

  // Watchdog control and core stall; stall drops in the valid cycle so the core advances once
  always_comb begin
    waiting     = (state_q != S_IDLE);
    timer_clear = !waiting || mem_ready || timer_hit;
    timer_en    = waiting && !mem_ready && !timer_hit;
    stall       = waiting || ((if_req || d_req) && !if_valid && !d_valid);
  end

  // FSM and registered memory/requester outputs; valid and err are single-cycle pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Data path wins over fetch when both request together
          if (d_req) begin
            state_q   <= S_D_WAIT;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (if_req) begin
            state_q  <= S_IF_WAIT;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        S_IF_WAIT: begin
          if (mem_ready) begin
            state_q  <= S_IDLE;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end else if (timer_hit) begin
            state_q  <= S_IDLE;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= '0;
            if_valid <= 1'b1;
            err      <= 1'b1;
          end
        end
        S_D_WAIT: begin
          if (mem_ready) begin
            state_q <= S_IDLE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            d_valid <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end else if (timer_hit) begin
            state_q <= S_IDLE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            d_valid <= 1'b1;
            err     <= 1'b1;
            // Stores keep the last load result
            if (!mem_we) begin
              d_rdata <= '0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed table, corner sequences,
// and random transactions checked against a transaction-level latency/data model.
module tb_mem_access_sequencer;

  localparam int T = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        err;
  logic        stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  mem_access_sequencer #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .err      (err),
    .stall    (stall),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          w;          // wait cycles before mem_ready (w > T never answers)
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access; expectations come from the vector, mem_ready driven by the bench
  task automatic run_txn(input vec_t v);
    int k_end;
    if_req    = !v.is_d;
    d_req     = v.is_d;
    d_we      = v.is_d & v.we;
    if_addr   = v.is_d ? $urandom : v.addr;
    d_addr    = v.is_d ? v.addr : $urandom;
    d_wdata   = v.wdata;
    mem_ready = 1'($urandom);  // ignored while idle
    mem_rdata = $urandom;
    @(negedge clk);
    chk("req_stall", stall, 1);
    chk("idle_quiet", {if_valid, d_valid, err, mem_en}, 0);
    k_end = (v.w <= T) ? v.w : T;
    for (int k = 0; k <= k_end; k++) begin
      step();
      // Scramble requester inputs: they must not be re-sampled mid-access
      if_addr   = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_we      = 1'($urandom);
      mem_ready = (k == v.w);
      mem_rdata = (k == v.w) ? v.rdata : $urandom;
      @(negedge clk);
      chk("mem_hold", {mem_en, mem_we, mem_addr}, {1'b1, v.is_d & v.we, v.addr});
      if (v.is_d && v.we) chk("mem_wdata", mem_wdata, v.wdata);
      chk("wait_flags", {stall, if_valid, d_valid}, 3'b100);
    end
    step();
    if_req    = 1'b0;
    d_req     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("complete", {if_valid, d_valid, err, mem_en, stall},
        {!v.is_d, v.is_d, v.exp_err, 1'b0, 1'b0});
    chk("rdata", v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    step();
  endtask

  vec_t tbl[8];
  vec_t rv;
  logic [31:0] d_rdata_m;

  initial begin
    reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {mem_en, mem_we, if_valid, d_valid, err, stall}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    reset = 1'b1;
    step();

    // Directed table (TIMEOUT = 4)
    tbl[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h8C220004, 0, 1'b0, 32'h8C220004};
    tbl[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h11112222, 1, 1'b0, 32'h11112222};
    tbl[2] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'h99999999, 3, 1'b0, 32'h11112222};
    tbl[3] = '{1'b1, 1'b0, 32'h300, 32'h0,        32'h77777777, 9, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h304, 32'h0,        32'hCAFEF00D, 4, 1'b0, 32'hCAFEF00D};
    tbl[5] = '{1'b0, 1'b0, 32'h48,  32'h0,        32'h00000055, 5, 1'b1, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 32'h208, 32'h0BADF00D, 32'h12121212, 4, 1'b0, 32'hCAFEF00D};
    tbl[7] = '{1'b0, 1'b0, 32'h4C,  32'h0,        32'h00A00093, 2, 1'b0, 32'h00A00093};
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Simultaneous requests: data first, then fetch after the idle/valid cycle
    if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h100; mem_ready = 0;
    @(negedge clk);
    chk("sim_stall", stall, 1);
    step();
    mem_ready = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("sim_d_mem", {mem_en, mem_we, mem_addr}, {2'b10, 32'h100});
    step();
    d_req = 0; mem_ready = 0;
    @(negedge clk);
    chk("sim_d_valid", {d_valid, if_valid, err, mem_en, stall}, 5'b10000);
    chk("sim_d_rdata", d_rdata, 32'h12345678);
    step();
    mem_ready = 1; mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("sim_if_mem", {mem_en, mem_we, mem_addr, stall}, {2'b10, 32'h44, 1'b1});
    step();
    if_req = 0; mem_ready = 0;
    @(negedge clk);
    chk("sim_if_valid", {if_valid, d_valid, err, stall}, 4'b1000);
    chk("sim_if_rdata", if_rdata, 32'hA5A5A5A5);
    step();

    // Asynchronous reset in the middle of a data access
    d_req = 1; d_we = 0; d_addr = 32'h400; mem_ready = 0;
    step();
    step();
    @(negedge clk);
    chk("pre_rst_en", mem_en, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst", {mem_en, d_valid, err}, 0);
    chk("async_rst_addr", mem_addr, 0);
    d_req = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("no_valid_after_rst", {d_valid, if_valid, mem_en}, 0);
    end
    step();
    rv = '{1'b0, 1'b0, 32'h80, 32'h0, 32'h00100073, 1, 1'b0, 32'h00100073};
    run_txn(rv);

    // Random transactions against the transaction-level model
    d_rdata_m = 32'h0;
    for (int i = 0; i < 40; i++) begin
      rv.is_d  = 1'($urandom);
      rv.we    = rv.is_d & 1'($urandom);
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.w     = int'($urandom_range(0, T + 2));
      if (rv.we && rv.w > T) rv.w = T;
      rv.exp_err = (rv.w > T);
      if (!rv.is_d) begin
        rv.exp_rdata = rv.exp_err ? 32'h0 : rv.rdata;
      end else if (rv.we) begin
        rv.exp_rdata = d_rdata_m;
      end else begin
        rv.exp_rdata = rv.exp_err ? 32'h0 : rv.rdata;
        d_rdata_m    = rv.exp_rdata;
      end
      run_txn(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sequences one shared single-ported memory between the instruction-fetch path (PC side) and the load/store path (ALU address / reg_data2 side) of the CS RISC core.
- Drives a stall to the program counter and register bank while an access is outstanding.
- Enforces a registered request/ready handshake toward memory with a wait-cycle watchdog.
- Lets the core move from ideal single-cycle caches to a real multi-cycle memory.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum wait cycles in a wait state before abort (range 1..65535)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle pulse: if_rdata valid
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (ALU result)
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle pulse: data access complete
- err  out  1  one-cycle pulse with if_valid/d_valid when the access timed out
- stall  out  1  hold PC and suppress RegWrite
- mem_en  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completes the access this cycle

Behaviour:
- Reset (asynchronous, reset=0):
  - State goes to IDLE.
  - All registered outputs clear to 0 immediately: mem_en, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, d_rdata, d_valid, err.
  - The wait counter clears to 0.
  - Reset mid-access abandons the access; no valid pulse follows.
- States: IDLE, IF_WAIT, D_WAIT. Encoding is 2 bits.
- IDLE:
  - If d_req=1, go to D_WAIT. Latch mem_addr<=d_addr, mem_wdata<=d_wdata, mem_we<=d_we, mem_en<=1.
  - Otherwise, if if_req=1, go to IF_WAIT. Latch mem_addr<=if_addr, mem_we<=0, mem_en<=1.
  - Data has priority over fetch when both are requested in the same cycle.
- IF_WAIT / D_WAIT:
  - mem_en, mem_we, mem_addr and mem_wdata hold stable. Requester inputs are not re-sampled.
  - On an edge with mem_ready=1:
    - Go to IDLE; mem_en<=0, mem_we<=0.
    - IF_WAIT: if_rdata<=mem_rdata, if_valid<=1.
    - D_WAIT load: d_rdata<=mem_rdata, d_valid<=1.
    - D_WAIT store: d_valid<=1; d_rdata holds its previous value.
  - On an edge with mem_ready=0, the wait counter increments.
  - When the counter equals TIMEOUT and mem_ready=0:
    - Go to IDLE; mem_en<=0.
    - Pulse the valid for the active path together with err=1.
    - Load/fetch data registers get 0.
  - mem_ready arriving in the same cycle the counter reaches TIMEOUT wins: normal completion, err=0.
  - The counter clears on every entry to IDLE.
- if_valid, d_valid and err are high for exactly one cycle.
- Latency:
  - Request seen in cycle N; mem_en=1 from cycle N+1.
  - If mem_ready=1 in cycle N+1, the valid pulse is in cycle N+2.
  - Minimum latency is 2 cycles. IDLE always occupies at least one cycle between accesses.
- stall (combinational) = (state != IDLE) | (state == IDLE & (if_req | d_req) & !if_valid & !d_valid).
  - stall drops in the cycle the valid pulse is high, so the core advances exactly once per completion.
- mem_ready while in IDLE is ignored.
- A requester dropping its req mid-wait is a protocol violation. The access still completes and the valid still pulses.

Decomposition:
- Shared package mem_seq_pkg holds the state encoding localparams (S_IDLE=0, S_IF_WAIT=1, S_D_WAIT=2) and TIMEOUT_DEFAULT=255.
- One sub-module, wait_timer: counter sized $clog2(TIMEOUT+1), with clear, enable, and a hit output (count==TIMEOUT).

Test Plan:
1. Fetch: if_req=1, if_addr=0x40, mem_ready high 1 cycle after mem_en, mem_rdata=0x8C220004 -> mem_addr=0x40 at N+1, if_valid and if_rdata=0x8C220004 at N+2, stall 1 in N and N+1, 0 in N+2.
2. Simultaneous: if_req=1 (addr 0x44) and d_req=1 load (addr 0x100) in the same cycle -> mem_addr=0x100 first and d_valid; then one IDLE cycle, then the fetch of 0x44 and if_valid.
3. Store with 3 wait cycles: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_we/mem_wdata stable for 4 cycles, d_valid pulse, d_rdata unchanged, err=0.
4. Timeout: TIMEOUT=4, mem_ready held 0 -> after 4 wait cycles, d_valid=1 with err=1, d_rdata=0, mem_en=0, state IDLE.
5. Boundary: mem_ready=1 exactly in the cycle the counter hits TIMEOUT -> normal completion with err=0 and data captured.
6. Reset mid-access: assert reset=0 asynchronously during D_WAIT -> mem_en drops without waiting for a clock edge, no d_valid pulse; after release, a new fetch completes normally.
